bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3 "double dabble") that sits directly upstream of the per-digit `hexdigit` seven-segment decoders. It converts an unsigned binary value into packed BCD nibbles, one nibble per display digit, plus leading-zero flags so the display stage can blank unused digits. It performs one shift per clock, uses a start/done handshake, and holds its last result stable between conversions.

---
 rtl/bin_to_bcd_seq.sv | 119 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary to packed BCD converter.
// Performs one shift per clock and reports leading-zero flags for display blanking.
module bin_to_bcd_seq #(
    parameter int IN_WIDTH = 16,
    parameter int DIGITS   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [DIGITS-1:0]     lead_zero
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_WIDTH + 1);

    localparam logic [DIGITS-1:0] LZ_RESET = {{(DIGITS-1){1'b1}}, 1'b0};
    localparam logic [CW-1:0]     LAST_CNT = CW'(IN_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              state;
    logic [IN_WIDTH-1:0] shreg;
    logic [BW-1:0]       work;
    logic                ovf_acc;
    logic [CW-1:0]       count;

    logic [BW-1:0]       adj;
    logic [BW-1:0]       work_nxt;
    logic [IN_WIDTH-1:0] shreg_nxt;
    logic                ovf_nxt;
    logic [DIGITS-1:0]   lz_nxt;
    logic                zero_above;
    logic                last;

    // Add-3 correction keeps every digit at or below 9 after the doubling shift
    always_comb begin
        adj = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
            end
        end
        work_nxt  = {adj[BW-2:0], shreg[IN_WIDTH-1]};
        shreg_nxt = {shreg[IN_WIDTH-2:0], 1'b0};
        ovf_nxt   = ovf_acc | adj[BW-1];
        last      = (count == LAST_CNT);
    end

    always_comb begin
        lz_nxt     = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (work_nxt[4*i +: 4] == 4'd0);
            lz_nxt[i]  = zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            shreg     <= '0;
            work      <= '0;
            ovf_acc   <= 1'b0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            ovf       <= 1'b0;
            lead_zero <= LZ_RESET;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shreg   <= bin;
                        work    <= '0;
                        ovf_acc <= 1'b0;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    work    <= work_nxt;
                    shreg   <= shreg_nxt;
                    ovf_acc <= ovf_nxt;
                    count   <= count + CW'(1);
                    if (last) begin
                        bcd       <= work_nxt;
                        ovf       <= ovf_nxt;
                        lead_zero <= lz_nxt;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq, default five digits plus a four-digit
// instance to exercise overflow.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bin;

    logic        busy, done, ovf;
    logic [19:0] bcd;
    logic [4:0]  lead_zero;

    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;
    logic [3:0]  lead_zero4;

    int vectors;
    int miscompares;
    int cyc;
    int bcnt;
    int pulses;

    bin_to_bcd_seq #(.IN_WIDTH(16), .DIGITS(5)) dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .ovf(ovf),
        .lead_zero(lead_zero)
    );

    bin_to_bcd_seq #(.IN_WIDTH(16), .DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy4), .done(done4), .bcd(bcd4), .ovf(ovf4),
        .lead_zero(lead_zero4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a conversion, then step until done; optionally disturb bin/start mid-shift
    task automatic convert(input logic [15:0] v, input bit disturb,
                           input logic [19:0] hold_exp,
                           output int c, output int b);
        bin   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        b = 0;
        while (!done && c < 40) begin
            if (busy) b++;
            if (c == 8) chk("hold_bcd", {12'd0, bcd}, {12'd0, hold_exp});
            if (disturb && c == 5) begin
                bin   = 16'd7;
                start = 1'b1;
            end else if (disturb && c == 6) begin
                start = 1'b0;
            end
            tick();
            c++;
        end
    endtask

    task automatic wait_done(output int c);
        c = 0;
        do begin
            tick();
            c++;
        end while (!done && c < 40);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        start = 1'b0;
        bin   = 16'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bcd", {12'd0, bcd}, 32'h0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_lz", {27'd0, lead_zero}, 32'b11110);
        chk("rst_lz4", {28'd0, lead_zero4}, 32'b1110);

        convert(16'd0, 1'b0, 20'h0, cyc, bcnt);
        chk("zero_lat", cyc, 16);
        chk("zero_busy", bcnt, 16);
        chk("zero_bcd", {12'd0, bcd}, 32'h0);
        chk("zero_ovf", {31'd0, ovf}, 32'd0);
        chk("zero_lz", {27'd0, lead_zero}, 32'b11110);
        tick();
        chk("zero_pulse", {31'd0, done}, 32'd0);
        tick();

        convert(16'd1234, 1'b0, 20'h0, cyc, bcnt);
        chk("d1234_lat", cyc, 16);
        chk("d1234_busy", bcnt, 16);
        chk("d1234_bcd", {12'd0, bcd}, 32'h01234);
        chk("d1234_lz", {27'd0, lead_zero}, 32'b10000);
        chk("d1234_ovf", {31'd0, ovf}, 32'd0);
        tick();
        chk("d1234_busy_low", {31'd0, busy}, 32'd0);
        tick();

        convert(16'd65535, 1'b1, 20'h01234, cyc, bcnt);
        chk("dmax_lat", cyc, 16);
        chk("dmax_bcd", {12'd0, bcd}, 32'h65535);
        chk("dmax_lz", {27'd0, lead_zero}, 32'b00000);
        chk("dmax_ovf", {31'd0, ovf}, 32'd0);
        chk("dmax4_bcd", {16'd0, bcd4}, 32'h5535);
        chk("dmax4_ovf", {31'd0, ovf4}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("dmax_no_extra_done", pulses, 0);
        chk("dmax_hold", {12'd0, bcd}, 32'h65535);

        convert(16'd12345, 1'b0, 20'h65535, cyc, bcnt);
        chk("d12345_bcd", {12'd0, bcd}, 32'h12345);
        chk("d12345_lz", {27'd0, lead_zero}, 32'b00000);
        chk("d12345_ovf", {31'd0, ovf}, 32'd0);
        chk("d4_done", {31'd0, done4}, 32'd1);
        chk("d4_ovf", {31'd0, ovf4}, 32'd1);
        chk("d4_bcd", {16'd0, bcd4}, 32'h2345);
        chk("d4_lz", {28'd0, lead_zero4}, 32'b0000);
        tick();
        tick();

        bin   = 16'd9;
        start = 1'b1;
        wait_done(cyc);
        chk("held9_bcd", {12'd0, bcd}, 32'h00009);
        chk("held9_lz", {27'd0, lead_zero}, 32'b11110);
        bin = 16'd10;
        wait_done(cyc);
        start = 1'b0;
        chk("held_gap", cyc, 18);
        chk("held10_bcd", {12'd0, bcd}, 32'h00010);
        chk("held10_lz", {27'd0, lead_zero}, 32'b11100);
        for (int i = 0; i < 22; i++) tick();

        bin   = 16'd4321;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_bcd", {12'd0, bcd}, 32'h0);
        chk("abort_ovf", {31'd0, ovf}, 32'd0);
        chk("abort_lz", {27'd0, lead_zero}, 32'b11110);
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("abort_no_done", pulses, 0);

        convert(16'd4321, 1'b0, 20'h0, cyc, bcnt);
        chk("d4321_lat", cyc, 16);
        chk("d4321_bcd", {12'd0, bcd}, 32'h04321);
        chk("d4321_lz", {27'd0, lead_zero}, 32'b10000);
        chk("d4321_4_bcd", {16'd0, bcd4}, 32'h4321);
        chk("d4321_4_ovf", {31'd0, ovf4}, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
